rpn_ctrl: RTL and testbench
===========================

Name: rpn_ctrl

Overview:
- Sequencing controller for the RPN calculator operand stack.
- Accepts a token stream of operands and operators. Operands are pushed onto the stack. Operators pop two operands, compute in an internal ALU and push the result.
- Sits between the token/keypad decoder upstream and the stack block. It is the only master of the stack's push/pop_ack side.
- Tracks stack depth and flags underflow, overflow and illegal-opcode errors.

Parameters:
- WIDTH, 8, data width of operands, stack entries and results.
- DEPTH, 16, stack capacity in entries; must match the attached stack instance.
- OPW, 3, opcode field width, taken from tok_data[OPW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; shared with the stack.
- tok_valid  in  1  token present.
- tok_ready  out  1  controller can accept a token.
- tok_is_op  in  1  1 = tok_data carries an opcode; 0 = operand value.
- tok_data  in  WIDTH  operand value or opcode.
- push  out  1  push request to stack.
- push_dat  out  WIDTH  data to push.
- push_ack  in  1  stack accepted push (one-cycle pulse).
- pop  in  1  stack top valid.
- pop_dat  in  WIDTH  stack top value.
- pop_ack  out  1  consume stack top.
- result  out  WIDTH  last value pushed by the controller.
- result_valid  out  1  one-cycle pulse when result updates.
- depth  out  $clog2(DEPTH+1)  current entry count.
- err_underflow  out  1  sticky: operator issued with depth < 2.
- err_overflow  out  1  sticky: operand or result push attempted at full depth.
- err_opcode  out  1  sticky: unsupported opcode.
- err_clr  in  1  synchronous clear of all error flags.

Behaviour:
- Reset (reset=0, async): state IDLE; depth=0; push=0; push_dat=0; pop_ack=0; result=0; result_valid=0; all err_* = 0; tok_ready=0 while in reset, then 1 from the first cycle after release. Reset asserted mid-operation aborts that operation; nothing is retried.
- Token accept: a token is accepted when tok_valid && tok_ready. tok_ready is 1 only in IDLE, so exactly one token is in flight.
- States: IDLE, PUSH_OPND, POP_B, POP_A, EXEC, PUSH_RES.
- IDLE, operand accepted:
  - depth==DEPTH: set err_overflow, drop the token, stay in IDLE.
  - otherwise: push_dat<=tok_data, push<=1, go to PUSH_OPND.
- IDLE, operator accepted:
  - illegal opcode: set err_opcode, stay in IDLE. Checked first.
  - depth<2: set err_underflow, stay in IDLE. Stack is untouched.
  - otherwise: latch the opcode, go to POP_B.
- PUSH_OPND / PUSH_RES:
  - push and push_dat held stable until push_ack=1.
  - On the push_ack edge: push<=0, depth+1, result<=push_dat, result_valid pulses the next cycle, go to IDLE.
  - A push_ack that arrives while push=0 is ignored.
- POP_B / POP_A:
  - pop_ack = state∈{POP_B,POP_A} && pop, combinational.
  - On that edge, pop_dat is latched into b (POP_B) or a (POP_A) and depth-1.
  - POP_B goes to POP_A; POP_A goes to EXEC. Wait indefinitely while pop=0.
- EXEC: one cycle. r = a op b, truncated to WIDTH (modular, unsigned). push_dat<=r, push<=1, go to PUSH_RES. The result push cannot overflow because depth ≤ DEPTH-2 at this point.
- Opcodes: 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 XOR; 5 MUL (feature-dependent); 6 DUP-free reserved; 6 and 7 are illegal.
- Errors:
  - Flags are sticky.
  - err_clr clears them.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Latency:
  - Operand: push is asserted the cycle after accept. Back in IDLE on the cycle after push_ack.
  - Operator with zero-wait stack: 5 cycles from accept to result_valid.
- depth saturates at 0..DEPTH by construction; no wrap-around.

Optional Feature:
- Macro RPN_MUL_EN.
- Defined: opcode 5 = a*b, low WIDTH bits kept. EXEC remains single-cycle.
- Undefined: opcode 5 is illegal and sets err_opcode. No multiplier is synthesized.

Decomposition:
- Shared package rpn_pkg holds:
  - opcode localparams OP_ADD..OP_MUL
  - state enum/localparams
  - default WIDTH and DEPTH constants
- The stack and token decoder import the same package.
- One sub-module, rpn_alu: combinational (a, b, op) -> r. It contains the RPN_MUL_EN guard.

Test Plan:
- Reset, then push operands 3 and 5, then ADD -> two push handshakes with push_dat 3, then 5; pops return 5 then 3; push_dat=8; result=8 with result_valid pulse; depth=1.
- Push 2, push 7, SUB -> result=0xFB (2−7 mod 256); push 0xF0, 0x3C, XOR -> result=0xCC.
- With depth=1, issue ADD -> err_underflow=1, no push/pop_ack activity, depth stays 1; err_clr pulse -> flag 0.
- Push 16 operands 0..F, then a 17th operand 0xB -> err_overflow=1, depth=16, no push issued. Then 15 ADDs -> result=0x78, depth=1.
- Opcode 5 with 6 and 7 on the stack -> result=42 with RPN_MUL_EN defined. Without the macro -> err_opcode=1 and depth stays 2. Opcode 7 -> err_opcode=1 in both builds.
- Stall the stack (push_ack delayed 3 cycles, pop held low 2 cycles) during MUL/ADD; assert reset low inside POP_A -> all outputs return to reset values asynchronously, depth=0, tok_ready=1 after release.

Source files
------------

// File: rtl/rpn_pkg.sv
// rpn_pkg: constants and types shared by the RPN calculator blocks
// (controller, stack, token decoder).
//   WIDTH_DEF / DEPTH_DEF / OPW_DEF : default data width, stack depth and
//                                     opcode width
//   OP_*                            : opcode encodings
//   state_e                         : controller sequencing states
package rpn_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned OPW_DEF   = 3;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_MUL = 5;

    typedef enum logic [2:0] {
        StIdle,
        StPushOpnd,
        StPopB,
        StPopA,
        StExec,
        StPushRes
    } state_e;

endpackage

// File: rtl/rpn_ctrl_if.sv
// rpn_ctrl_if: push/pop handshake between the RPN controller and the
// operand stack.
//   push / push_dat / push_ack : controller writes a new top entry
//   pop / pop_dat / pop_ack    : stack offers its top entry, controller consumes it
// Modports: master = controller side, slave = stack side.
interface rpn_ctrl_if
    import rpn_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             push;
    logic [WIDTH-1:0] push_dat;
    logic             push_ack;
    logic             pop;
    logic [WIDTH-1:0] pop_dat;
    logic             pop_ack;

    modport master (
        output push,
        output push_dat,
        output pop_ack,
        input  push_ack,
        input  pop,
        input  pop_dat
    );

    modport slave (
        input  push,
        input  push_dat,
        input  pop_ack,
        output push_ack,
        output pop,
        output pop_dat
    );

endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational RPN operator unit, r = a op b truncated to WIDTH.
//   a, b  : operands (a is the deeper stack entry)
//   op    : opcode
//   r     : result (0 for unsupported opcodes)
//   legal : opcode is supported by this build
// Build option: define RPN_MUL_EN to implement opcode 5 (multiply); without
// it opcode 5 is reported illegal and no multiplier exists.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] r,
    output logic             legal
);

    always_comb begin
        r     = '0;
        legal = 1'b1;
        case (32'(op))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
`ifdef RPN_MUL_EN
            OP_MUL:  r = a * b;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: sequencing controller for the RPN calculator operand stack.
// Operands are pushed; operators pop b then a, compute a op b and push the
// result. One token is in flight at a time.
//   clk, reset (async, active-low)
//   tok_valid/tok_ready/tok_is_op/tok_data : token stream from the decoder
//   stk (rpn_ctrl_if.master)               : push/pop handshake to the stack
//   result/result_valid                    : last value pushed, update pulse
//   depth                                  : current stack entry count
//   err_underflow/err_overflow/err_opcode  : sticky error flags, err_clr clears
// Build option: RPN_MUL_EN (see rpn_alu) enables the multiply opcode.
module rpn_ctrl
    import rpn_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned OPW   = OPW_DEF,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_data,
    rpn_ctrl_if.master       stk,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [DW-1:0]    depth,
    output logic             err_underflow,
    output logic             err_overflow,
    output logic             err_opcode,
    input  logic             err_clr
);

    state_e           state_q, state_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             push_q, push_d;
    logic [WIDTH-1:0] push_dat_q, push_dat_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rv_q, rv_d;
    logic             unf_q, unf_d, ovf_q, ovf_d, opc_q, opc_d;
    logic             set_unf, set_ovf, set_opc;

    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_r;
    logic             alu_legal;

    // In IDLE the ALU decodes the incoming opcode for the legality check;
    // elsewhere it works on the latched opcode.
    assign alu_op = (state_q == StIdle) ? tok_data[OPW-1:0] : op_q;

    rpn_alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (alu_op),
        .r     (alu_r),
        .legal (alu_legal)
    );

    // Gated with reset so the decoder sees no readiness while held in reset.
    assign tok_ready     = reset && (state_q == StIdle);
    assign stk.push      = push_q;
    assign stk.push_dat  = push_dat_q;
    assign stk.pop_ack   = ((state_q == StPopB) || (state_q == StPopA)) && stk.pop;
    assign result        = result_q;
    assign result_valid  = rv_q;
    assign depth         = depth_q;
    assign err_underflow = unf_q;
    assign err_overflow  = ovf_q;
    assign err_opcode    = opc_q;

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        push_d     = push_q;
        push_dat_d = push_dat_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;
        rv_d       = 1'b0;
        set_unf    = 1'b0;
        set_ovf    = 1'b0;
        set_opc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tok_valid) begin
                    if (!tok_is_op) begin
                        if (depth_q == DW'(DEPTH)) begin
                            set_ovf = 1'b1;
                        end else begin
                            push_d     = 1'b1;
                            push_dat_d = tok_data;
                            state_d    = StPushOpnd;
                        end
                    end else if (!alu_legal) begin
                        set_opc = 1'b1;
                    end else if (depth_q < DW'(2)) begin
                        set_unf = 1'b1;
                    end else begin
                        op_d    = tok_data[OPW-1:0];
                        state_d = StPopB;
                    end
                end
            end
            StPushOpnd, StPushRes: begin
                if (push_q && stk.push_ack) begin
                    push_d   = 1'b0;
                    depth_d  = depth_q + DW'(1);
                    result_d = push_dat_q;
                    rv_d     = 1'b1;
                    state_d  = StIdle;
                end
            end
            StPopB: begin
                if (stk.pop) begin
                    b_d     = stk.pop_dat;
                    depth_d = depth_q - DW'(1);
                    state_d = StPopA;
                end
            end
            StPopA: begin
                if (stk.pop) begin
                    a_d     = stk.pop_dat;
                    depth_d = depth_q - DW'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                push_dat_d = alu_r;
                push_d     = 1'b1;
                state_d    = StPushRes;
            end
            default: state_d = StIdle;
        endcase

        // A new error in the same cycle as err_clr stays set.
        unf_d = (err_clr ? 1'b0 : unf_q) | set_unf;
        ovf_d = (err_clr ? 1'b0 : ovf_q) | set_ovf;
        opc_d = (err_clr ? 1'b0 : opc_q) | set_opc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            depth_q    <= '0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            rv_q       <= 1'b0;
            unf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            opc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            push_q     <= push_d;
            push_dat_q <= push_dat_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            rv_q       <= rv_d;
            unf_q      <= unf_d;
            ovf_q      <= ovf_d;
            opc_q      <= opc_d;
        end
    end

endmodule

// File: tb/tb_rpn_ctrl.sv
// tb_rpn_ctrl: directed self-checking bench for rpn_ctrl with a behavioural
// operand stack (configurable push_ack delay and pop stall).
module tb_rpn_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tok_valid, tok_is_op, err_clr;
    logic [7:0] tok_data;
    logic       tok_ready;
    logic [7:0] result;
    logic       result_valid;
    logic [4:0] depth;
    logic       err_underflow, err_overflow, err_opcode;

    rpn_ctrl_if #(.WIDTH(8)) stk ();

    rpn_ctrl #(
        .WIDTH (8),
        .DEPTH (16),
        .OPW   (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .tok_is_op     (tok_is_op),
        .tok_data      (tok_data),
        .stk           (stk),
        .result        (result),
        .result_valid  (result_valid),
        .depth         (depth),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_opcode    (err_opcode),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    // Behavioural stack
    logic [7:0] mem [0:15];
    int         sp;
    int         cnt;
    int         ack_delay;
    logic       pop_block;
    logic [7:0] push_log [$];
    logic [7:0] pop_log [$];

    assign stk.pop     = (sp > 0) && !pop_block;
    assign stk.pop_dat = (sp > 0) ? mem[sp-1] : 8'h00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp           <= 0;
            cnt          <= 0;
            stk.push_ack <= 1'b0;
        end else begin
            if (stk.pop_ack) begin
                pop_log.push_back(stk.pop_dat);
                sp <= sp - 1;
            end
            if (stk.push && !stk.push_ack) begin
                if (cnt >= ack_delay && sp < 16) begin
                    stk.push_ack <= 1'b1;
                    mem[sp]      <= stk.push_dat;
                    push_log.push_back(stk.push_dat);
                    sp           <= sp + 1;
                    cnt          <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                stk.push_ack <= 1'b0;
                cnt          <= 0;
            end
        end
    end

    // Activity counters
    int push_cyc = 0, pa_cyc = 0, rv_cnt = 0;
    always @(negedge clk) begin
        if (stk.push)     push_cyc <= push_cyc + 1;
        if (stk.pop_ack)  pa_cyc   <= pa_cyc + 1;
        if (result_valid) rv_cnt   <= rv_cnt + 1;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (tok_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $error("FAIL ready_timeout: observed tok_ready %0b expected 1", tok_ready);
        end
    endtask

    task automatic send(input logic op, input logic [7:0] d);
        wait_ready();
        tok_valid = 1'b1;
        tok_is_op = op;
        tok_data  = d;
        @(negedge clk);
        tok_valid = 1'b0;
    endtask

    // Send a token and wait until the controller is idle again.
    task automatic token(input logic op, input logic [7:0] d);
        send(op, d);
        wait_ready();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int p0, q0, c0, r0, a0;
        reset     = 1'b0;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = 8'h00;
        err_clr   = 1'b0;
        ack_delay = 0;
        pop_block = 1'b0;

        // Reset state
        #12;
        chk("rst_tok_ready", tok_ready, 0);
        chk("rst_depth", depth, 0);
        chk("rst_push", stk.push, 0);
        chk("rst_push_dat", stk.push_dat, 0);
        chk("rst_pop_ack", stk.pop_ack, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_errs", {err_underflow, err_overflow, err_opcode}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_tok_ready", tok_ready, 1);

        // 3 5 ADD
        p0 = push_log.size();
        q0 = pop_log.size();
        r0 = rv_cnt;
        token(0, 8'd3);
        token(0, 8'd5);
        token(1, 8'd0);
        chk("add_push0", push_log[p0], 8'd3);
        chk("add_push1", push_log[p0+1], 8'd5);
        chk("add_push2", push_log[p0+2], 8'd8);
        chk("add_pop0", pop_log[q0], 8'd5);
        chk("add_pop1", pop_log[q0+1], 8'd3);
        chk("add_result", result, 8'd8);
        chk("add_depth", depth, 1);
        chk("add_rv_pulses", rv_cnt - r0, 3);

        // Underflow at depth 1
        c0 = push_cyc;
        a0 = pa_cyc;
        token(1, 8'd0);
        chk("unf_flag", err_underflow, 1);
        chk("unf_no_push", push_cyc - c0, 0);
        chk("unf_no_pop", pa_cyc - a0, 0);
        chk("unf_depth", depth, 1);
        pulse_clr();
        chk("unf_clr", err_underflow, 0);

        // 2 7 SUB
        token(0, 8'd2);
        token(0, 8'd7);
        token(1, 8'd1);
        chk("sub_result", result, 8'hFB);
        chk("sub_depth", depth, 2);
        // F0 3C XOR, then OR, then AND
        token(0, 8'hF0);
        token(0, 8'h3C);
        token(1, 8'd4);
        chk("xor_result", result, 8'hCC);
        chk("xor_depth", depth, 3);
        token(1, 8'd3);
        chk("or_result", result, 8'hFF);
        token(1, 8'd2);
        chk("and_result", result, 8'h08);
        chk("and_depth", depth, 1);

        // Fill to capacity, then overflow together with err_clr
        do_reset();
        for (int i = 0; i < 16; i++) token(0, 8'(i));
        chk("full_depth", depth, 16);
        chk("full_no_ovf", err_overflow, 0);
        p0 = push_log.size();
        c0 = push_cyc;
        err_clr = 1'b1;
        send(0, 8'h0B);
        err_clr = 1'b0;
        @(negedge clk);
        chk("ovf_flag_set_wins", err_overflow, 1);
        chk("ovf_depth", depth, 16);
        chk("ovf_no_push", push_cyc - c0, 0);
        chk("ovf_no_log", push_log.size() - p0, 0);
        for (int i = 0; i < 15; i++) token(1, 8'd0);
        chk("sum_result", result, 8'h78);
        chk("sum_depth", depth, 1);
        chk("ovf_sticky", err_overflow, 1);

        // Opcode 5 and illegal opcodes
        do_reset();
        token(0, 8'd6);
        token(0, 8'd7);
        token(1, 8'd5);
`ifdef RPN_MUL_EN
        chk("mul_result", result, 8'd42);
        chk("mul_depth", depth, 1);
        chk("mul_no_err", err_opcode, 0);
`else
        chk("mul_illegal", err_opcode, 1);
        chk("mul_depth", depth, 2);
        chk("mul_result_kept", result, 8'd7);
`endif
        pulse_clr();
        chk("opc_clr", err_opcode, 0);
        token(1, 8'd7);
        chk("op7_illegal", err_opcode, 1);
        pulse_clr();
        token(1, 8'd6);
        chk("op6_illegal", err_opcode, 1);
        chk("op6_no_unf", err_underflow, 0);

        // Stalled stack
        do_reset();
        ack_delay = 3;
        token(0, 8'd10);
        token(0, 8'd20);
        q0 = pop_log.size();
        pop_block = 1'b1;
        send(1, 8'd0);
        @(negedge clk);
        @(negedge clk);
        chk("stall_pop_ack", stk.pop_ack, 0);
        chk("stall_depth", depth, 2);
        pop_block = 1'b0;
        wait_ready();
        @(negedge clk);
        chk("stall_result", result, 8'd30);
        chk("stall_depth_end", depth, 1);
        chk("stall_pop0", pop_log[q0], 8'd20);
        chk("stall_pop1", pop_log[q0+1], 8'd10);

        // Reset inside POP_A
        token(0, 8'd1);
        token(0, 8'd2);
        send(1, 8'd0);
        @(negedge clk);
        pop_block = 1'b1;
        chk("popa_depth", depth, 2);
        @(negedge clk);
        chk("popa_stalled", depth, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_depth", depth, 0);
        chk("async_push", stk.push, 0);
        chk("async_push_dat", stk.push_dat, 0);
        chk("async_pop_ack", stk.pop_ack, 0);
        chk("async_result", result, 0);
        chk("async_rv", result_valid, 0);
        chk("async_tok_ready", tok_ready, 0);
        @(negedge clk);
        reset     = 1'b1;
        pop_block = 1'b0;
        c0        = push_cyc;
        @(negedge clk);
        chk("post_tok_ready", tok_ready, 1);
        chk("post_depth", depth, 0);
        @(negedge clk);
        chk("post_no_retry", push_cyc - c0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1);
    end

endmodule
